// File: rtl/profile_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : profile_window_ctrl_if
// Description : Custom-instruction bus and event bundle for the profiling
//               window controller.
//               master : CPU/bench side. Drives start, ciN, valueA, valueB
//                        and the event inputs stall, busIdle, userEvent.
//                        Receives done, result, windowActive, windowDone.
//               slave  : Controller side, with the opposite directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface profile_window_ctrl_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        stall;
    logic        busIdle;
    logic        userEvent;
    logic        done;
    logic [31:0] result;
    logic        windowActive;
    logic        windowDone;

    modport master (
        output start, ciN, valueA, valueB, stall, busIdle, userEvent,
        input  done, result, windowActive, windowDone
    );

    modport slave (
        input  start, ciN, valueA, valueB, stall, busIdle, userEvent,
        output done, result, windowActive, windowDone
    );
endinterface
`default_nettype wire

// File: rtl/profile_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : profile_window_ctrl
// Description : Custom-instruction driven profiling window. It holds four
//               saturating 32-bit event counters that count only while a
//               programmable-length window is running.
//               The counters are C0 cycles, C1 stall, C2 busIdle and
//               C3 userEvent.
// Ports       : clock  - system clock; all state changes on its rising edge
//               reset  - asynchronous active-high reset
//               bus    - profile_window_ctrl_if.slave. It carries the
//                        instruction strobe and operands, the event inputs,
//                        the done/result response and the window status.
// Opcodes     : valueA[2:0] selects the operation:
//               0 SETMASK, 1 SETLEN, 2 START, 3 ABORT, 4 STATUS, 5 READ.
//               Opcodes 6 and 7 do nothing.
// Revision    : 1.0 - initial release
// ============================================================================
module profile_window_ctrl #(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic                 clock,
    input  logic                 reset,
    profile_window_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_SETMASK = 3'd0;
    localparam logic [2:0] OP_SETLEN  = 3'd1;
    localparam logic [2:0] OP_START   = 3'd2;
    localparam logic [2:0] OP_ABORT   = 3'd3;
    localparam logic [2:0] OP_STATUS  = 3'd4;
    localparam logic [2:0] OP_READ    = 3'd5;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]        state_q,     state_d;
    logic [3:0]        mask_q,      mask_d;
    logic [31:0]       length_q,    length_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [3:0][31:0]  cnt_q,       cnt_d;
    logic [3:0]        sat_q,       sat_d;
    logic              done_q,      done_d;
    logic [31:0]       result_q,    result_d;

    logic              addressed;
    logic [2:0]        opcode;
    logic [3:0]        event_vec;
    logic [31:0]       instr_result;

    // Only the opcode field of valueA has meaning.
    logic unused_valuea_hi;
    assign unused_valuea_hi = &{1'b0, bus.valueA[31:3]};

    assign addressed = bus.start && (bus.ciN == customId);
    assign opcode    = bus.valueA[2:0];
    // C0 counts every window cycle, so its event is tied high.
    assign event_vec = {bus.userEvent, bus.busIdle, bus.stall, 1'b1};

    // Instruction result. READ and STATUS show the register values from
    // before this cycle's update, so READ gives the live count during RUN.
    always_comb begin
        instr_result = 32'd0;
        if (opcode == OP_STATUS) begin
            instr_result = {24'd0, sat_q, 2'b00,
                            (state_q == ST_DONE), (state_q == ST_RUN)};
        end else if (opcode == OP_READ) begin
            instr_result = cnt_q[bus.valueB[1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        length_d    = length_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        done_d      = addressed;
        result_d    = addressed ? instr_result : 32'd0;

        if (addressed && (opcode == OP_SETMASK)) begin
            mask_d = bus.valueB[3:0];
        end
        if (addressed && (opcode == OP_SETLEN)) begin
            length_d = bus.valueB;
        end

        if (addressed && (opcode == OP_START)) begin
            // START overrides the window update in the same cycle. This
            // covers a START on the expiry cycle and stops events from
            // being counted on the START cycle itself.
            cnt_d       = '0;
            sat_d       = '0;
            remaining_d = length_q;
            state_d     = (length_q == 32'd0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_RUN) begin
            for (int n = 0; n < 4; n++) begin
                if (mask_q[n] && event_vec[n]) begin
                    if (cnt_q[n] != CNT_MAX) begin
                        cnt_d[n] = cnt_q[n] + 32'd1;
                    end
                    // The flag goes up as the counter reaches its ceiling.
                    if (cnt_q[n] >= (CNT_MAX - 32'd1)) begin
                        sat_d[n] = 1'b1;
                    end
                end
            end
            remaining_d = remaining_q - 32'd1;
            // An ABORT cycle is still a window cycle, so it is counted.
            if (addressed && (opcode == OP_ABORT)) begin
                state_d = ST_IDLE;
            end else if (remaining_q == 32'd1) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= 4'd0;
            length_q    <= 32'd0;
            remaining_q <= 32'd0;
            cnt_q       <= '0;
            sat_q       <= 4'd0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            length_q    <= length_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.windowActive = (state_q == ST_RUN);
    assign bus.windowDone   = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_profile_window_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_profile_window_ctrl
// Description : Bench for profile_window_ctrl. Directed instructions push
//               their hand-computed result and issue cycle into a queue.
//               A negedge monitor pops an entry on every done pulse and
//               checks the value and the one-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_profile_window_ctrl;

    localparam logic [7:0] ID = 8'h5A;

    localparam logic [31:0] OP_SETMASK = 32'd0;
    localparam logic [31:0] OP_SETLEN  = 32'd1;
    localparam logic [31:0] OP_START   = 32'd2;
    localparam logic [31:0] OP_ABORT   = 32'd3;
    localparam logic [31:0] OP_STATUS  = 32'd4;
    localparam logic [31:0] OP_READ    = 32'd5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    profile_window_ctrl_if bus_if();

    profile_window_ctrl #(.customId(ID)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] mon_exp;
    int          mon_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. It occupies exactly one cycle and returns at
    // the next negedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        bus_if.start  = 1'b1;
        bus_if.ciN    = ID;
        bus_if.valueA = a;
        bus_if.valueB = b;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc);
        @(negedge clk);
        bus_if.start  = 1'b0;
        bus_if.valueA = 32'd0;
        bus_if.valueB = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: result %h with no instruction pending", bus_if.result);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_cyc = cyc_q.pop_front();
                    if (bus_if.result !== mon_exp || cyc != mon_cyc + 1) begin
                        errors++;
                        $display("FAIL response: got result %h at cycle %0d, expected %h at cycle %0d",
                                 bus_if.result, cyc, mon_exp, mon_cyc + 1);
                    end
                end
            end else begin
                checks++;
                if (bus_if.result !== 32'd0) begin
                    errors++;
                    $display("FAIL result_idle: got %h while done low, expected 00000000", bus_if.result);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.ciN       = 8'd0;
        bus_if.valueA    = 32'd0;
        bus_if.valueB    = 32'd0;
        bus_if.stall     = 1'b0;
        bus_if.busIdle   = 1'b0;
        bus_if.userEvent = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done",   {31'd0, bus_if.done},         32'd0);
        chk("rst_result", bus_if.result,                32'd0);
        chk("rst_active", {31'd0, bus_if.windowActive}, 32'd0);
        chk("rst_wdone",  {31'd0, bus_if.windowDone},   32'd0);
        reset = 1'b0;

        // First instruction after reset.
        issue(OP_STATUS, 0, 32'd0);

        // Basic window of 10 cycles. Stall is high for 3 cycles and
        // userEvent for 1. busIdle is high on the START cycle, which
        // must not count, and on all 10 window cycles.
        issue(OP_SETMASK, 32'hF, 32'd0);
        issue(OP_SETLEN, 32'd10, 32'd0);
        bus_if.busIdle = 1'b1;
        issue(OP_START, 0, 32'd0);
        bus_if.userEvent = 1'b1;
        idle(1);
        bus_if.userEvent = 1'b0;
        idle(1);
        bus_if.stall = 1'b1;
        idle(3);
        bus_if.stall = 1'b0;
        idle(4);
        chk("w10_active_last", {31'd0, bus_if.windowActive}, 32'd1);
        chk("w10_wdone_early", {31'd0, bus_if.windowDone},   32'd0);
        idle(1);
        bus_if.busIdle = 1'b0;
        chk("w10_wdone",  {31'd0, bus_if.windowDone},   32'd1);
        chk("w10_active", {31'd0, bus_if.windowActive}, 32'd0);
        issue(OP_READ, 0, 32'd10);
        issue(OP_READ, 1, 32'd3);
        issue(OP_READ, 2, 32'd10);
        issue(OP_READ, 3, 32'd1);
        issue(OP_STATUS, 0, 32'h2);

        // A zero-length window completes immediately.
        issue(OP_SETLEN, 0, 32'd0);
        issue(OP_START, 0, 32'd0);
        chk("len0_wdone", {31'd0, bus_if.windowDone}, 32'd1);
        for (int n = 0; n < 4; n++) issue(OP_READ, n, 32'd0);
        issue(OP_STATUS, 0, 32'h2);

        // ABORT on window cycle 20, then the count must hold.
        issue(OP_SETLEN, 32'd100, 32'd0);
        issue(OP_START, 0, 32'd0);
        idle(19);
        issue(OP_ABORT, 0, 32'd0);
        issue(OP_STATUS, 0, 32'd0);
        issue(OP_READ, 0, 32'd20);
        idle(50);
        issue(OP_READ, 0, 32'd20);
        issue(OP_ABORT, 0, 32'd0);
        issue(32'h0000_0006, 0, 32'd0);
        issue(32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'd0);
        issue(32'hABCD_0005, 0, 32'd20);
        issue(OP_STATUS, 0, 32'd0);

        // A START on the expiry cycle restarts the window.
        issue(OP_SETLEN, 32'd5, 32'd0);
        issue(OP_START, 0, 32'd0);
        idle(4);
        issue(OP_START, 0, 32'd0);
        chk("restart_active", {31'd0, bus_if.windowActive}, 32'd1);
        idle(4);
        issue(OP_READ, 0, 32'd4);
        issue(OP_READ, 0, 32'd5);
        issue(OP_STATUS, 0, 32'h2);

        // Saturation. C0 is preloaded close to its ceiling.
        issue(OP_SETMASK, 32'h1, 32'd0);
        issue(OP_SETLEN, 32'hFFFF_FFFF, 32'd0);
        issue(OP_START, 0, 32'd0);
        force dut.cnt_q = {96'd0, 32'hFFFF_FFFD};
        #1;
        release dut.cnt_q;
        idle(4);
        issue(OP_READ, 0, 32'hFFFF_FFFF);
        issue(OP_STATUS, 0, 32'h11);
        issue(OP_ABORT, 0, 32'd0);
        issue(OP_STATUS, 0, 32'h10);

        // Reset asserted during RUN while done is high.
        issue(OP_SETMASK, 32'hF, 32'd0);
        issue(OP_SETLEN, 32'd100, 32'd0);
        issue(OP_START, 0, 32'd0);
        idle(5);
        bus_if.start  = 1'b1;
        bus_if.ciN    = ID;
        bus_if.valueA = OP_STATUS;
        bus_if.valueB = 32'd0;
        @(posedge clk);
        #2;
        chk("pre_rst_done",   {31'd0, bus_if.done},         32'd1);
        chk("pre_rst_result", bus_if.result,                32'h1);
        bus_if.start = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_rst_done",   {31'd0, bus_if.done},         32'd0);
        chk("async_rst_result", bus_if.result,                32'd0);
        chk("async_rst_active", {31'd0, bus_if.windowActive}, 32'd0);
        chk("async_rst_wdone",  {31'd0, bus_if.windowDone},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_READ, 0, 32'd0);
        issue(OP_STATUS, 0, 32'd0);

        // A START with a foreign instruction number has no effect.
        bus_if.start  = 1'b1;
        bus_if.ciN    = ID ^ 8'hFF;
        bus_if.valueA = OP_START;
        @(negedge clk);
        chk("unaddr_done", {31'd0, bus_if.done}, 32'd0);
        bus_if.start  = 1'b0;
        bus_if.valueA = 32'd0;
        issue(OP_STATUS, 0, 32'd0);
        // The length was cleared by reset, so this START goes straight to DONE.
        issue(OP_START, 0, 32'd0);
        issue(OP_STATUS, 0, 32'h2);

        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/profile_window_ctrl.md
PROFILE_WINDOW_CTRL -- requirements
Module: profile_window_ctrl

Interface
REQ-001 Parameter: customId, default 8'h00, custom-instruction number the block responds to.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  custom-instruction start strobe, one cycle.
REQ-005 ciN  input  8  custom-instruction number; the block is addressed when ciN == customId and start == 1.
REQ-006 valueA  input  32  opcode in valueA[2:0]; bits [31:3] ignored.
REQ-007 valueB  input  32  operand: mask, window length or counter index, depending on opcode.
REQ-008 stall  input  1  CPU stall event.
REQ-009 busIdle  input  1  bus idle event.
REQ-010 userEvent  input  1  external event source.
REQ-011 done  output  1  registered one-cycle completion pulse.
REQ-012 result  output  32  registered instruction result; 0 whenever done == 0.
REQ-013 windowActive  output  1  high while state == RUN.
REQ-014 windowDone  output  1  high while state == DONE.

Function
REQ-015 Four 32-bit event counters SHALL be kept: C0 cycles, C1 stall, C2 busIdle, C3 userEvent.
REQ-016 A 4-bit enable mask register and a 32-bit window length register SHALL be kept; remaining (32-bit) SHALL count down the active window.
REQ-017 The state machine SHALL have states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-018 When addressed at cycle t, the block SHALL assert done at t+1 for exactly one cycle, with result valid in the same cycle.
REQ-019 Unaddressed cycles SHALL have no effect on state, registers or outputs.
REQ-020 Opcode 0 (SETMASK): mask <= valueB[3:0]; result = 0.
REQ-021 Opcode 1 (SETLEN): length <= valueB; result = 0; accepted in any state and applied at the next START.
REQ-022 Opcode 2 (START), any state: clear C0..C3 and the saturation flags; remaining <= length; go to RUN, or to DONE if length == 0; result = 0.
REQ-023 Opcode 3 (ABORT): RUN -> IDLE with counters held; no effect in IDLE or DONE; result = 0.
REQ-024 Opcode 4 (STATUS): result = {24'd0, satFlags[3:0], 2'b00, state==DONE, state==RUN}.
REQ-025 Opcode 5 (READ): result = Cn with n = valueB[1:0]; live value while in RUN.
REQ-026 Opcodes 6 and 7: done pulses, result = 0, no side effects.
REQ-027 In RUN, each cycle Cn SHALL increment by 1 if mask[n] == 1 and its event input is high (C0 event always high).
REQ-028 Counting begins in the cycle after START, so C0 = length at window end when mask[0] == 1.
REQ-029 In RUN, remaining SHALL decrement each cycle; when remaining == 1, next state is DONE, so exactly length cycles are counted.
REQ-030 Counters SHALL saturate at 32'hFFFFFFFF and set satFlags[n]; they SHALL NOT wrap.
REQ-031 In DONE and IDLE, counters SHALL hold; DONE SHALL persist until START or reset.
REQ-032 A START issued in the cycle where the window would expire SHALL take priority: counters clear and RUN restarts.
REQ-033 An event input that is high on the START cycle SHALL NOT be counted.

Reset
REQ-034 Reset SHALL clear, at any time and including mid-window, all of: state to IDLE; mask, length, remaining, C0..C3 and satFlags to 0; done, result, windowActive and windowDone to 0.
REQ-035 After reset deasserts, the first addressed instruction SHALL be handled normally with latency 1.

Verification
REQ-036 SETMASK 4'hF, SETLEN 10, START; stall high for 3 cycles in the window -> windowDone 10 cycles after START; READ 0 = 10; READ 1 = 3.
REQ-037 SETLEN 0, START -> windowDone at t+1; READ 0..3 all = 0; STATUS = 32'h2.
REQ-038 SETLEN 100, START, ABORT at window cycle 20 -> STATUS = 0; READ 0 = 20; value held for 50 further cycles.
REQ-039 Mask 4'h1, length 32'hFFFFFFFF, C0 forced near saturation via a long run or a bench-side preload -> C0 stops at FFFFFFFF; STATUS bit 4 = 1.
REQ-040 START on the expiry cycle of a length-5 window -> state remains RUN; C0 = 5 after 5 more cycles.
REQ-041 Reset asserted mid-RUN -> all outputs 0 asynchronously; READ 0 after release = 0; ciN != customId with start high -> done stays 0.
